// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NREQ valid/ready streams into one registered output stream.
// Each grant passes up to BURST beats, then one IDLE cycle before the next search.
//
// state | meaning
// IDLE  | no owner; search upward from ptr for the next valid requester
// GRANT | grant_id owns the output until BURST beats or its ivalid drops
module stream_rr_arbiter #(
    parameter int STREAMW = 32,
    parameter int NREQ    = 4,
    parameter int BURST   = 8,
    localparam int GW     = $clog2(NREQ),
    localparam int CW     = $clog2(BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ*STREAMW-1:0] in_data,
    input  logic [NREQ-1:0]         ivalid,
    output logic [NREQ-1:0]         iready,
    input  logic                    oready,
    output logic                    ovalid,
    output logic [STREAMW-1:0]      out_data,
    output logic [GW-1:0]           grant_id,
    output logic                    busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] sel;
    logic [GW-1:0] next_ptr;
    logic [CW-1:0] count;
    logic          accept;

    assign busy     = (state == GRANT);
    assign accept   = ivalid[grant_id] && iready[grant_id];
    assign next_ptr = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        iready = '0;
        if (state == GRANT && (!ovalid || oready))
            iready[grant_id] = 1'b1;
    end

    // Scan downward so the last hit is the first valid requester at or above ptr.
    always_comb begin
        sel = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (ivalid[(int'(ptr) + k) % NREQ])
                sel = GW'((int'(ptr) + k) % NREQ);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            count    <= '0;
            grant_id <= '0;
            ovalid   <= 1'b0;
            out_data <= '0;
        end else begin
            if (accept) begin
                out_data <= in_data[grant_id*STREAMW +: STREAMW];
                ovalid   <= 1'b1;
            end else if (oready) begin
                ovalid   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|ivalid) begin
                        grant_id <= sel;
                        count    <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        if (count == CW'(BURST - 1)) begin
                            state <= IDLE;
                            ptr   <= next_ptr;
                        end
                    end else if (!ivalid[grant_id]) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: transaction-level reference model,
// output scoreboard and directed scenarios plus a randomized run.
module tb_stream_rr_arbiter;
    localparam int W     = 32;
    localparam int NREQ  = 4;
    localparam int BURST = 8;
    localparam int GW    = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ*W-1:0]    in_data = '0;
    logic [NREQ-1:0]      ivalid = '0;
    logic [NREQ-1:0]      iready;
    logic                 oready = 1'b0;
    logic                 ovalid;
    logic [W-1:0]         out_data;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    stream_rr_arbiter #(.STREAMW(W), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .ivalid(ivalid), .iready(iready),
        .oready(oready), .ovalid(ovalid), .out_data(out_data), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: owner = -1 means no grant is held.
    int           m_owner, m_ptr, m_beats, m_gid;
    logic         m_ov;
    logic [W-1:0] m_od;
    int           seq [NREQ];
    logic [W-1:0] sb_q [$];

    function automatic logic [W-1:0] src_word(input int i);
        return {8'(i), 24'(seq[i])};
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_beats = 0; m_gid = 0;
        m_ov = 1'b0; m_od = '0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        ivalid = '0; oready = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    // One clock: drive at negedge, check iready and scoreboard, step model, check registers.
    task automatic step(input logic [NREQ-1:0] v, input logic r);
        int n_owner, n_ptr, n_beats, n_gid, acc_id;
        logic n_ov;
        logic [W-1:0] n_od, exp_w;
        logic [NREQ-1:0] m_ir;
        bit found;
        @(negedge clk);
        ivalid = v; oready = r;
        for (int i = 0; i < NREQ; i++) in_data[i*W +: W] = src_word(i);
        #1;
        m_ir = '0;
        if (m_owner >= 0 && (!m_ov || r)) m_ir[m_owner] = 1'b1;
        checks++;
        if (iready !== m_ir) begin
            errors++; $display("FAIL iready got %b want %b", iready, m_ir);
        end
        if (ovalid === 1'b1 && r) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL sb_extra_beat got %h want none", out_data);
            end else begin
                exp_w = sb_q.pop_front();
                if (out_data !== exp_w) begin
                    errors++; $display("FAIL sb_data got %h want %h", out_data, exp_w);
                end
            end
        end
        n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats; n_gid = m_gid;
        n_ov = m_ov; n_od = m_od; acc_id = -1;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && v[(m_ptr + k) % NREQ]) begin
                    found = 1; n_owner = (m_ptr + k) % NREQ; n_gid = n_owner; n_beats = 0;
                end
            end
            if (r) n_ov = 1'b0;
        end else if (v[m_owner] && m_ir[m_owner]) begin
            acc_id = m_owner;
            n_od = src_word(m_owner); n_ov = 1'b1; n_beats = m_beats + 1;
            if (n_beats == BURST) begin n_owner = -1; n_ptr = (m_owner + 1) % NREQ; end
        end else begin
            if (r) n_ov = 1'b0;
            if (!v[m_owner]) begin n_owner = -1; n_ptr = (m_owner + 1) % NREQ; end
        end
        @(posedge clk); #1;
        m_owner = n_owner; m_ptr = n_ptr; m_beats = n_beats; m_gid = n_gid;
        m_ov = n_ov; m_od = n_od;
        if (acc_id >= 0) begin sb_q.push_back(n_od); seq[acc_id]++; end
        checks += 4;
        if (ovalid !== m_ov) begin errors++; $display("FAIL ovalid got %b want %b", ovalid, m_ov); end
        if (out_data !== m_od) begin errors++; $display("FAIL out_data got %h want %h", out_data, m_od); end
        if (grant_id !== GW'(m_gid)) begin errors++; $display("FAIL grant_id got %0d want %0d", grant_id, m_gid); end
        if (busy !== (m_owner >= 0)) begin errors++; $display("FAIL busy got %b want %b", busy, m_owner >= 0); end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (ovalid !== 1'b0 || out_data !== '0 || iready !== '0 || busy !== 1'b0 || grant_id !== '0) begin
            errors++;
            $display("FAIL %s got ov=%b od=%h ir=%b busy=%b gid=%0d want all zero",
                     tag, ovalid, out_data, iready, busy, grant_id);
        end
    endtask

    task automatic test_reset();
        ivalid = '1; oready = 1'b1; rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < 2 * (BURST + 1) + 2; k++) begin
            step(4'b0100, 1'b1);
            checks += 2;
            if (grant_id !== GW'(2)) begin errors++; $display("FAIL single_gid got %0d want 2", grant_id); end
            if (busy !== ((k % (BURST + 1)) != BURST)) begin
                errors++; $display("FAIL single_busy cycle %0d got %b want %b", k, busy, (k % (BURST + 1)) != BURST);
            end
        end
    endtask

    task automatic test_all_valid();
        int order [$];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic prev_busy;
        do_reset();
        prev_busy = 1'b0;
        for (int k = 0; k < 5 * (BURST + 1) + 2; k++) begin
            step('1, 1'b1);
            if (busy && !prev_busy) order.push_back(int'(grant_id));
            prev_busy = busy;
        end
        checks++;
        if (order.size() < 5) begin
            errors++; $display("FAIL rr_grants got %0d want >=5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++; $display("FAIL rr_order idx %0d got %0d want %0d", i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        do_reset();
        repeat (4) step('1, 1'b1);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            step('1, 1'b0);
            checks += 2;
            if (ovalid !== 1'b1) begin errors++; $display("FAIL bp_ovalid got %b want 1", ovalid); end
            if (out_data !== held) begin errors++; $display("FAIL bp_stable got %h want %h", out_data, held); end
        end
        repeat (20) step('1, 1'b1);
    endtask

    task automatic test_early_release();
        int guard;
        do_reset();
        guard = 0;
        while (!(m_owner == 1 && m_beats == 3) && guard < 20) begin
            step(4'b1010, 1'b1); guard++;
        end
        checks++;
        if (guard >= 20) begin errors++; $display("FAIL early_setup got timeout want 3 beats on 1"); end
        step(4'b1000, 1'b1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL early_idle got %b want 0", busy); end
        step(4'b1000, 1'b1);
        checks++;
        if (busy !== 1'b1 || grant_id !== GW'(3)) begin
            errors++; $display("FAIL early_regrant got busy=%b gid=%0d want busy=1 gid=3", busy, grant_id);
        end
        repeat (3) step(4'b1000, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (3) step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        checks++;
        if (busy !== 1'b1 || grant_id !== GW'(0)) begin
            errors++; $display("FAIL wrap got busy=%b gid=%0d want busy=1 gid=0", busy, grant_id);
        end
        repeat (3) step(4'b0001, 1'b1);
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        step('1, 1'b1);
        guard = 0;
        while (m_beats < 4 && guard < 20) begin step('1, 1'b1); guard++; end
        checks++;
        if (guard >= 20) begin errors++; $display("FAIL rmid_setup got timeout want beat 4"); end
        rst = 1'b0;
        #1 check_reset_outputs("rmid_async");
        ivalid = 4'b0110;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rmid_held");
        rst = 1'b1;
        model_reset();
        step(4'b0110, 1'b1);
        checks++;
        if (busy !== 1'b1 || grant_id !== GW'(1)) begin
            errors++; $display("FAIL rmid_regrant got busy=%b gid=%0d want busy=1 gid=1", busy, grant_id);
        end
        repeat (4) step(4'b0110, 1'b1);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v;
        do_reset();
        v = NREQ'($urandom);
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(7) == 0) v[i] = ~v[i];
            step(v, $urandom_range(3) != 0);
        end
        repeat (BURST + 4) step('0, 1'b1);
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d want 0", sb_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) seq[i] = i * 1000;
        model_reset();
        test_reset();
        test_single();
        test_all_valid();
        test_backpressure();
        test_early_release();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter STREAMW, default 32, data width per stream.
REQ-002 SHALL have parameter NREQ, default 4, number of upstream requesters (2..8).
REQ-003 SHALL have parameter BURST, default 8, maximum beats per grant before re-arbitration (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, NREQ*STREAMW, requester i data in bits [i*STREAMW +: STREAMW].
REQ-007 SHALL have port ivalid, input, NREQ, per-requester valid.
REQ-008 SHALL have port iready, output, NREQ, per-requester ready.
REQ-009 SHALL have port oready, input, 1, downstream ready (e.g. from stream_buffer iready).
REQ-010 SHALL have port ovalid, output, 1, registered output valid.
REQ-011 SHALL have port out_data, output, STREAMW, registered output data.
REQ-012 SHALL have port grant_id, output, clog2(NREQ), index of the currently or last granted requester.
REQ-013 SHALL have port busy, output, 1, high while in GRANT state.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE, GRANT.
REQ-015 In IDLE, if any ivalid is high, SHALL select the first requester with ivalid high, searching upward from pointer ptr with wrap modulo NREQ.
- Registered transition: on the next edge, grant_id <= selection, beat count <= 0, state <= GRANT.
REQ-016 In IDLE, iready SHALL be all zeros.
REQ-017 In GRANT, iready[i] SHALL equal (i==grant_id) && (!ovalid || oready); all other bits SHALL be 0.
REQ-018 A beat SHALL be accepted when ivalid[grant_id] && iready[grant_id].
REQ-019 On accept: out_data <= in_data slice of grant_id, ovalid <= 1.
- Latency is exactly 1 cycle from accept to ovalid.
REQ-020 Without accept, if oready is high, ovalid SHALL clear to 0; otherwise ovalid and out_data SHALL hold.
REQ-021 out_data SHALL never change while ovalid && !oready.
REQ-022 On each accept, the beat count SHALL increment.
- Accept with count == BURST-1: state <= IDLE, ptr <= (grant_id+1) mod NREQ.
REQ-023 In GRANT with ivalid[grant_id] low: state <= IDLE, ptr <= (grant_id+1) mod NREQ, regardless of count.
REQ-024 In GRANT with ivalid[grant_id] high and iready low (downstream stall): SHALL hold state, count and grant.
REQ-025 Requests from non-granted requesters during GRANT SHALL be ignored until the return to IDLE.
REQ-026 Every re-grant SHALL pass through exactly one IDLE cycle.
- Maximum throughput is BURST beats per BURST+1 cycles under continuous requests.
REQ-027 ptr wrap: from grant_id == NREQ-1 the next ptr SHALL be 0.
REQ-028 With all requesters continuously valid, grants SHALL rotate 0,1,...,NREQ-1,0 with no starvation.
REQ-029 grant_id SHALL hold its last value through IDLE.
REQ-030 busy SHALL equal (state == GRANT).

Reset
REQ-031 While rst is low, the block SHALL asynchronously force: state=IDLE, ptr=0, count=0, grant_id=0, ovalid=0, out_data=0, iready=0, busy=0.
REQ-032 Reset asserted mid-burst SHALL drop the in-flight output beat (ovalid=0).
- After release, arbitration SHALL restart from ptr=0.
REQ-033 The first grant SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 Single requester: ivalid=4'b0100 continuously, oready=1, BURST=8.
- Expected: grant_id=2; 8 beats per grant, each with ovalid one cycle after accept; one idle cycle, then re-grant to 2.
REQ-035 All requesters valid, oready=1.
- Expected: grant order 0,1,2,3,0; each grant passes exactly 8 beats; out_data matches the source sequence per requester.
REQ-036 Backpressure: oready=0 for 5 cycles mid-burst.
- Expected: ovalid held high, out_data stable, iready[g]=0, count frozen; no beat lost or duplicated after oready=1.
REQ-037 Early release: requester 1 drops ivalid after 3 beats while requester 3 is valid.
- Expected: IDLE for 1 cycle, then grant to 3; ptr=2 before the search.
REQ-038 Wrap: requester 3 is granted, then only requester 0 is valid.
- Expected: next grant_id=0.
REQ-039 Reset mid-burst: rst low for 2 cycles during beat 4.
- Expected: all outputs reach reset values immediately, without waiting for a clock edge; after release, the lowest valid index from 0 is granted.
